// File: rtl/adder_tree_accumulator_16bit.sv
// rtl/adder_tree_accumulator_16bit.sv - row accumulator for 16-bit adder-tree partial sums
//
// Purpose: sums a programmable number of unsigned 16-bit partial sums from the
// adder tree into one ACC_W-bit row result, presented with a valid/ready handshake.
//
// Ports:
//   i_clk        clock, all logic on posedge
//   i_reset      synchronous active-high reset
//   i_start      row start pulse, honoured only when idle
//   i_num_terms  terms in the row, sampled on an accepted start
//   i_sum_in     partial sum from the adder tree
//   i_sum_valid  i_sum_in carries a term this cycle
//   o_acc_out    final row sum, stable while o_acc_valid=1
//   o_acc_valid  o_acc_out is valid
//   i_acc_ready  downstream accepts o_acc_out
//   o_busy       row in progress or result waiting
//   o_drop_err   sticky: a term arrived while not accumulating
//   o_sat_flag   sticky per row: accumulator clamped
//
// Build option: define ACC_SATURATE_EN to clamp on overflow instead of wrapping.

module adder_tree_accumulator_16bit #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_num_terms,
  input  logic [15:0]      i_sum_in,
  input  logic             i_sum_valid,
  output logic [ACC_W-1:0] o_acc_out,
  output logic             o_acc_valid,
  input  logic             i_acc_ready,
  output logic             o_busy,
  output logic             o_drop_err,
  output logic             o_sat_flag
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_acc_out;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] r_num_terms;
  logic             r_drop_err;
  logic             w_start_ok;
  logic             w_term;
  logic             w_last;
  logic [ACC_W-1:0] w_acc_next;

  assign w_start_ok = (r_state == S_IDLE) && i_start;
  assign w_term     = (r_state == S_ACCUM) && i_sum_valid;
  assign w_last     = w_term && (r_count == (r_num_terms - LEN_W'(1)));

`ifdef ACC_SATURATE_EN
  logic [ACC_W:0] w_sum;
  logic           w_ovf;
  logic           r_sat_flag;

  // One extra bit catches the carry out; once clamped to all-ones any further
  // non-zero term overflows again, so the row stays clamped without extra state.
  assign w_sum      = {1'b0, r_acc} + (ACC_W+1)'(i_sum_in);
  assign w_ovf      = w_sum[ACC_W];
  assign w_acc_next = w_ovf ? '1 : w_sum[ACC_W-1:0];
  assign o_sat_flag = r_sat_flag;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sat_flag <= 1'b0;
    end else if (w_start_ok) begin
      r_sat_flag <= 1'b0;
    end else if (w_term && w_ovf) begin
      r_sat_flag <= 1'b1;
    end
  end
`else
  assign w_acc_next = r_acc + ACC_W'(i_sum_in);
  assign o_sat_flag = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = (i_num_terms == '0) ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_last) begin
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_acc_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    o_acc_valid = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      S_ACCUM: o_busy = 1'b1;
      S_HOLD: begin
        o_busy      = 1'b1;
        o_acc_valid = 1'b1;
      end
      default: begin
        o_busy      = 1'b0;
        o_acc_valid = 1'b0;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc       <= '0;
      r_acc_out   <= '0;
      r_count     <= '0;
      r_num_terms <= '0;
      r_drop_err  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_num_terms <= i_num_terms;
        r_acc       <= '0;
        r_count     <= '0;
        // An empty row resolves immediately to zero.
        if (i_num_terms == '0) begin
          r_acc_out <= '0;
        end
      end
      if (w_term) begin
        r_acc   <= w_acc_next;
        r_count <= r_count + LEN_W'(1);
        if (w_last) begin
          r_acc_out <= w_acc_next;
        end
      end
      if (i_sum_valid && (r_state != S_ACCUM)) begin
        r_drop_err <= 1'b1;
      end
    end
  end

  assign o_acc_out  = r_acc_out;
  assign o_drop_err = r_drop_err;

endmodule

// File: tb/tb_adder_tree_accumulator_16bit.sv
// tb/tb_adder_tree_accumulator_16bit.sv - self-checking bench for adder_tree_accumulator_16bit

module tb_adder_tree_accumulator_16bit;

`ifdef ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  num_terms;
  logic [15:0] sum_in;
  logic        sum_valid;
  logic        acc_ready;

  logic [31:0] a_acc_out;
  logic        a_acc_valid, a_busy, a_drop_err, a_sat_flag;
  logic [16:0] b_acc_out;
  logic        b_acc_valid, b_busy, b_drop_err, b_sat_flag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adder_tree_accumulator_16bit #(.ACC_W(32), .LEN_W(8)) u_dut_a (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_num_terms(num_terms),
    .i_sum_in(sum_in), .i_sum_valid(sum_valid), .o_acc_out(a_acc_out),
    .o_acc_valid(a_acc_valid), .i_acc_ready(acc_ready), .o_busy(a_busy),
    .o_drop_err(a_drop_err), .o_sat_flag(a_sat_flag));

  adder_tree_accumulator_16bit #(.ACC_W(17), .LEN_W(8)) u_dut_b (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_num_terms(num_terms),
    .i_sum_in(sum_in), .i_sum_valid(sum_valid), .o_acc_out(b_acc_out),
    .o_acc_valid(b_acc_valid), .i_acc_ready(acc_ready), .o_busy(b_busy),
    .o_drop_err(b_drop_err), .o_sat_flag(b_sat_flag));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned lim(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Row result from the exact (unbounded) sum of its terms.
  function automatic longint unsigned fin(input longint unsigned t, input int w);
    if (SAT) return (t > lim(w)) ? lim(w) : t;
    return t & lim(w);
  endfunction

  // Behavioural model: phase 0 idle, 1 collecting terms, 2 result offered.
  int              m_phase;
  int              m_rem;
  longint unsigned m_total;
  longint unsigned m_out_a, m_out_b;
  bit              m_sat_a, m_sat_b, m_drop;
  bit              m_live = 1'b0;

  always @(posedge clk) begin : model
    int              ph, rem;
    longint unsigned tot, oa, ob;
    bit              sa, sb, dr;
    ph = m_phase; rem = m_rem; tot = m_total; oa = m_out_a; ob = m_out_b;
    sa = m_sat_a; sb = m_sat_b; dr = m_drop;
    if (reset) begin
      ph = 0; rem = 0; tot = 0; oa = 0; ob = 0; sa = 0; sb = 0; dr = 0;
      m_live <= 1'b1;
    end else if (ph == 0) begin
      if (sum_valid) dr = 1;
      if (start) begin
        sa = 0; sb = 0;
        if (num_terms == 0) begin
          oa = 0; ob = 0; ph = 2;
        end else begin
          rem = num_terms; tot = 0; ph = 1;
        end
      end
    end else if (ph == 1) begin
      if (sum_valid) begin
        tot = tot + sum_in;
        rem = rem - 1;
        if (SAT && tot > lim(32)) sa = 1;
        if (SAT && tot > lim(17)) sb = 1;
        if (rem == 0) begin
          oa = fin(tot, 32); ob = fin(tot, 17); ph = 2;
        end
      end
    end else begin
      if (sum_valid) dr = 1;
      if (acc_ready) ph = 0;
    end
    m_phase <= ph; m_rem <= rem; m_total <= tot; m_out_a <= oa; m_out_b <= ob;
    m_sat_a <= sa; m_sat_b <= sb; m_drop <= dr;
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("a_acc_out",   64'(a_acc_out),   64'(m_out_a));
      check("a_acc_valid", 64'(a_acc_valid), 64'(m_phase == 2));
      check("a_busy",      64'(a_busy),      64'(m_phase != 0));
      check("a_drop_err",  64'(a_drop_err),  64'(m_drop));
      check("a_sat_flag",  64'(a_sat_flag),  64'(m_sat_a));
      check("b_acc_out",   64'(b_acc_out),   64'(m_out_b));
      check("b_acc_valid", 64'(b_acc_valid), 64'(m_phase == 2));
      check("b_busy",      64'(b_busy),      64'(m_phase != 0));
      check("b_drop_err",  64'(b_drop_err),  64'(m_drop));
      check("b_sat_flag",  64'(b_sat_flag),  64'(m_sat_b));
    end
  end

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; sum_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_start(input int nt);
    start = 1'b1; num_terms = 8'(nt);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_term(input int v);
    sum_valid = 1'b1; sum_in = 16'(v);
    @(negedge clk);
    sum_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_terms = '0; sum_in = '0; sum_valid = 1'b0; acc_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_acc_out", 64'(a_acc_out), 64'd0);
    check("reset_busy", 64'(a_busy), 64'd0);
    reset = 1'b0;

    // Four back-to-back terms
    send_start(4);
    send_term(10); send_term(20); send_term(30); send_term(40);
    check("t1_valid", 64'(a_acc_valid), 64'd1);
    check("t1_sum", 64'(a_acc_out), 64'd100);
    @(negedge clk);
    check("t1_valid_drop", 64'(a_acc_valid), 64'd0);

    // Maximum terms with stall gaps
    send_start(3);
    send_term(65535); repeat (2) @(negedge clk);
    send_term(65535); repeat (2) @(negedge clk);
    send_term(65535);
    check("t2_sum32", 64'(a_acc_out), 64'd196605);
    check("t2_sum17", 64'(b_acc_out), SAT ? 64'd131071 : 64'd65533);
    check("t2_sat17", 64'(b_sat_flag), SAT ? 64'd1 : 64'd0);
    @(negedge clk);

    // Back-pressure with stray terms and starts while holding
    acc_ready = 1'b0;
    send_start(4);
    send_term(1); send_term(2); send_term(3); send_term(4);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; num_terms = 8'd2; sum_valid = 1'b1; sum_in = 16'($urandom);
      @(negedge clk);
      check("t3_hold_valid", 64'(a_acc_valid), 64'd1);
      check("t3_hold_sum", 64'(a_acc_out), 64'd10);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; sum_valid = 1'b0;
    check("t3_drop", 64'(a_drop_err), 64'd1);
    check("t3_idle", 64'(a_busy), 64'd0);

    // Empty row, then a stray term in idle
    do_reset();
    send_start(0);
    check("t4_valid", 64'(a_acc_valid), 64'd1);
    check("t4_sum", 64'(a_acc_out), 64'd0);
    @(negedge clk);
    send_term(7);
    check("t4_drop", 64'(a_drop_err), 64'd1);

    // Reset mid-row leaves no residue
    send_start(4);
    send_term(7); send_term(8);
    do_reset();
    check("t5_busy", 64'(a_busy), 64'd0);
    check("t5_drop", 64'(a_drop_err), 64'd0);
    send_start(2);
    send_term(5); send_term(6);
    check("t5_sum", 64'(a_acc_out), 64'd11);
    @(negedge clk);

    // Overflow at 17 bits
    send_start(3);
    send_term(65535); send_term(65535); send_term(10);
    check("t6_sum17", 64'(b_acc_out), SAT ? 64'd131071 : 64'd8);
    check("t6_sat17", 64'(b_sat_flag), SAT ? 64'd1 : 64'd0);
    check("t6_sum32", 64'(a_acc_out), 64'd131080);
    check("t6_sat32", 64'(a_sat_flag), 64'd0);
    @(negedge clk);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 399) == 0);
      start     = ($urandom_range(0, 3) == 0);
      num_terms = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      sum_valid = ($urandom_range(0, 3) != 0);
      sum_in    = ($urandom_range(0, 2) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3)) : 16'($urandom);
      acc_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0; sum_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
